// File: rtl/i2c_byte_sequencer.sv
// i2c_byte_sequencer
//   Byte-level I2C command sequencer between the register front end and the
//   bit-level SCL/SDA engine. One byte command (start/stop/read/write, tx byte,
//   master ack bit) becomes START, 8 data bits, an ACK bit and STOP. Each bit
//   command is handed to the bit engine with an i_bit_ack handshake. One
//   o_cmd_ack strobe is returned per byte command, either on completion or on
//   arbitration loss.
// Ports
//   clk, rst          clock (rising edge), asynchronous active-low reset
//   i_core_rst        synchronous active-high soft reset, same effect as rst
//   i_ena             enables acceptance of new commands
//   i_start/i_stop    START before / STOP after the data phase
//   i_read/i_write    data phase direction (read has priority)
//   i_ack_in          master ACK bit after a read (1 = NACK)
//   i_din             byte to transmit, sampled at acceptance
//   o_cmd_ack         one-cycle strobe: byte command complete or aborted
//   o_ack_out         slave ACK bit after a write (1 = NACK)
//   o_dout            received byte
//   o_busy            sequencer not idle
//   o_bit_cmd/o_bit_din  bit-engine command (NOP/START/STOP/WRITE/READ) and SDA
//   i_bit_ack/i_bit_dout/i_bit_al  bit-engine done strobe, sampled SDA, arb lost
module i2c_byte_sequencer (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_core_rst,
  input  logic       i_ena,
  input  logic       i_start,
  input  logic       i_stop,
  input  logic       i_read,
  input  logic       i_write,
  input  logic       i_ack_in,
  input  logic [7:0] i_din,
  output logic       o_cmd_ack,
  output logic       o_ack_out,
  output logic [7:0] o_dout,
  output logic       o_busy,
  output logic [2:0] o_bit_cmd,
  output logic       o_bit_din,
  input  logic       i_bit_ack,
  input  logic       i_bit_dout,
  input  logic       i_bit_al
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_WRITE = 3'd2;
  localparam logic [2:0] ST_READ  = 3'd3;
  localparam logic [2:0] ST_ACK   = 3'd4;
  localparam logic [2:0] ST_STOP  = 3'd5;

  localparam logic [2:0] CMD_NOP   = 3'd0;
  localparam logic [2:0] CMD_START = 3'd1;
  localparam logic [2:0] CMD_STOP  = 3'd2;
  localparam logic [2:0] CMD_WRITE = 3'd3;
  localparam logic [2:0] CMD_READ  = 3'd4;

  logic [2:0] r_state;
  logic [7:0] r_sreg;
  logic [2:0] r_cnt;
  logic       r_rd;

  logic [2:0] w_state;
  logic [7:0] w_sreg;
  logic [2:0] w_cnt;
  logic       w_rd;
  logic [2:0] w_cmd;
  logic       w_din;
  logic       w_cmd_ack;
  logic       w_ack_out;
  logic [7:0] w_dout;
  logic       w_accept;

  // o_cmd_ack high last cycle blocks acceptance so the front end has one
  // cycle to clear its command bits.
  assign w_accept = i_ena & (i_start | i_stop | i_read | i_write) & ~o_cmd_ack;

  // DONE is folded into the transition back to IDLE: the finishing edge loads
  // IDLE, NOP and the o_cmd_ack strobe together.
  always_comb begin
    w_state   = r_state;
    w_sreg    = r_sreg;
    w_cnt     = r_cnt;
    w_rd      = r_rd;
    w_cmd     = o_bit_cmd;
    w_din     = o_bit_din;
    w_cmd_ack = 1'b0;
    w_ack_out = o_ack_out;
    w_dout    = o_dout;

    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_sreg = i_din;
          w_cnt  = 3'd7;
          w_din  = 1'b0;
          if (i_start) begin
            w_state = ST_START;
            w_cmd   = CMD_START;
          end else if (i_read) begin
            w_state = ST_READ;
            w_cmd   = CMD_READ;
            w_rd    = 1'b1;
          end else if (i_write) begin
            w_state = ST_WRITE;
            w_cmd   = CMD_WRITE;
            w_din   = i_din[7];
            w_rd    = 1'b0;
          end else begin
            w_state = ST_STOP;
            w_cmd   = CMD_STOP;
          end
        end
      end
      ST_START: begin
        if (i_bit_ack) begin
          w_din = 1'b0;
          if (i_read) begin
            w_state = ST_READ;
            w_cmd   = CMD_READ;
            w_rd    = 1'b1;
          end else if (i_write) begin
            w_state = ST_WRITE;
            w_cmd   = CMD_WRITE;
            w_din   = r_sreg[7];
            w_rd    = 1'b0;
          end else if (i_stop) begin
            w_state = ST_STOP;
            w_cmd   = CMD_STOP;
          end else begin
            w_state   = ST_IDLE;
            w_cmd     = CMD_NOP;
            w_cmd_ack = 1'b1;
          end
        end
      end
      ST_WRITE: begin
        if (i_bit_ack) begin
          w_sreg = {r_sreg[6:0], 1'b0};
          if (r_cnt == 3'd0) begin
            w_state = ST_ACK;
            w_cmd   = CMD_READ;
            w_din   = 1'b0;
          end else begin
            w_cnt = r_cnt - 3'd1;
            w_din = r_sreg[6];  // MSB of the shifted register
          end
        end
      end
      ST_READ: begin
        if (i_bit_ack) begin
          w_sreg = {r_sreg[6:0], i_bit_dout};
          if (r_cnt == 3'd0) begin
            w_state = ST_ACK;
            w_cmd   = CMD_WRITE;
            w_din   = i_ack_in;
          end else begin
            w_cnt = r_cnt - 3'd1;
          end
        end
      end
      ST_ACK: begin
        if (i_bit_ack) begin
          if (r_rd) w_dout    = r_sreg;
          else      w_ack_out = i_bit_dout;
          w_din = 1'b0;
          if (i_stop) begin
            w_state = ST_STOP;
            w_cmd   = CMD_STOP;
          end else begin
            w_state   = ST_IDLE;
            w_cmd     = CMD_NOP;
            w_cmd_ack = 1'b1;
          end
        end
      end
      ST_STOP: begin
        if (i_bit_ack) begin
          w_state   = ST_IDLE;
          w_cmd     = CMD_NOP;
          w_din     = 1'b0;
          w_cmd_ack = 1'b1;
        end
      end
      default: begin
        w_state = ST_IDLE;
        w_cmd   = CMD_NOP;
        w_din   = 1'b0;
      end
    endcase

    // Arbitration loss overrides any bit_ack taken above; results untouched.
    if ((r_state != ST_IDLE) && i_bit_al) begin
      w_state   = ST_IDLE;
      w_sreg    = r_sreg;
      w_cnt     = r_cnt;
      w_cmd     = CMD_NOP;
      w_din     = 1'b0;
      w_cmd_ack = 1'b1;
      w_ack_out = o_ack_out;
      w_dout    = o_dout;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_sreg    <= '0;
      r_cnt     <= '0;
      r_rd      <= 1'b0;
      o_bit_cmd <= CMD_NOP;
      o_bit_din <= 1'b0;
      o_cmd_ack <= 1'b0;
      o_ack_out <= 1'b0;
      o_dout    <= '0;
      o_busy    <= 1'b0;
    end else if (i_core_rst) begin
      r_state   <= ST_IDLE;
      r_sreg    <= '0;
      r_cnt     <= '0;
      r_rd      <= 1'b0;
      o_bit_cmd <= CMD_NOP;
      o_bit_din <= 1'b0;
      o_cmd_ack <= 1'b0;
      o_ack_out <= 1'b0;
      o_dout    <= '0;
      o_busy    <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_sreg    <= w_sreg;
      r_cnt     <= w_cnt;
      r_rd      <= w_rd;
      o_bit_cmd <= w_cmd;
      o_bit_din <= w_din;
      o_cmd_ack <= w_cmd_ack;
      o_ack_out <= w_ack_out;
      o_dout    <= w_dout;
      o_busy    <= (w_state != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_i2c_byte_sequencer.sv
// tb_i2c_byte_sequencer
//   Directed bench for i2c_byte_sequencer. A behavioural bit engine acks each
//   bit command after a programmable number of cycles, logs the commands it
//   saw and feeds read data from a queue.
module tb_i2c_byte_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       i_core_rst;
  logic       i_ena;
  logic       i_start;
  logic       i_stop;
  logic       i_read;
  logic       i_write;
  logic       i_ack_in;
  logic [7:0] i_din;
  logic       o_cmd_ack;
  logic       o_ack_out;
  logic [7:0] o_dout;
  logic       o_busy;
  logic [2:0] o_bit_cmd;
  logic       o_bit_din;
  logic       i_bit_ack;
  logic       i_bit_dout;
  logic       i_bit_al;

  always #5 clk = ~clk;

  i2c_byte_sequencer u_dut (
    .clk        (clk),
    .rst        (rst),
    .i_core_rst (i_core_rst),
    .i_ena      (i_ena),
    .i_start    (i_start),
    .i_stop     (i_stop),
    .i_read     (i_read),
    .i_write    (i_write),
    .i_ack_in   (i_ack_in),
    .i_din      (i_din),
    .o_cmd_ack  (o_cmd_ack),
    .o_ack_out  (o_ack_out),
    .o_dout     (o_dout),
    .o_busy     (o_busy),
    .o_bit_cmd  (o_bit_cmd),
    .o_bit_din  (o_bit_din),
    .i_bit_ack  (i_bit_ack),
    .i_bit_dout (i_bit_dout),
    .i_bit_al   (i_bit_al)
  );

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;

  int unsigned lat  = 1;
  int unsigned wcnt = 0;
  int unsigned n_cack = 0;
  logic [2:0]  log_c[$];
  logic        log_d[$];
  bit          dq[$];

  // Bit engine and cmd_ack monitor, acting on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (o_cmd_ack === 1'b1) n_cack++;
      i_bit_ack = 1'b0;
      if (o_bit_cmd != 3'd0) begin
        if (wcnt >= lat) begin
          log_c.push_back(o_bit_cmd);
          log_d.push_back(o_bit_din);
          i_bit_dout = 1'b0;
          if (o_bit_cmd == 3'd4 && dq.size() > 0) i_bit_dout = dq.pop_front();
          i_bit_ack = 1'b1;
          wcnt = 0;
        end else begin
          wcnt++;
        end
      end else begin
        wcnt = 0;
      end
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int unsigned n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic wait_ack(input string tag);
    int unsigned k = 0;
    while (o_cmd_ack !== 1'b1 && k < 400) begin
      step(1);
      k++;
    end
    check_eq({tag, "_ack"}, 64'(o_cmd_ack), 64'd1);
  endtask

  task automatic clear_cmd();
    i_start = 1'b0;
    i_stop  = 1'b0;
    i_read  = 1'b0;
    i_write = 1'b0;
  endtask

  task automatic clear_log();
    log_c.delete();
    log_d.delete();
    dq.delete();
  endtask

  // Command trace packed 3 bits per entry; din of every WRITE packed 1 bit each.
  task automatic log_sig(output logic [63:0] sig, output logic [15:0] wb);
    sig = '0;
    wb  = '0;
    foreach (log_c[i]) begin
      sig = {sig[60:0], log_c[i]};
      if (log_c[i] == 3'd3) wb = {wb[14:0], log_d[i]};
    end
  endtask

  // Expected trace: optional START, 8 data bits, ACK bit in the other direction, optional STOP.
  function automatic logic [63:0] exp_sig(input bit st, input bit rd, input bit sp);
    logic [63:0] s = '0;
    if (st) s = {s[60:0], 3'd1};
    repeat (8) s = {s[60:0], (rd ? 3'd4 : 3'd3)};
    s = {s[60:0], (rd ? 3'd3 : 3'd4)};
    if (sp) s = {s[60:0], 3'd2};
    return s;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned n0;
    int unsigned k;
    int unsigned first;
    int unsigned nn;
    logic [63:0] sig;
    logic [15:0] wb;

    rst = 1'b0; i_core_rst = 1'b0; i_ena = 1'b0; i_ack_in = 1'b0; i_din = '0;
    i_start = 1'b0; i_stop = 1'b0; i_read = 1'b0; i_write = 1'b0;
    i_bit_ack = 1'b0; i_bit_dout = 1'b0; i_bit_al = 1'b0;
    step(3);
    check_eq("rst_cmd",    64'(o_bit_cmd), 64'd0);
    check_eq("rst_din",    64'(o_bit_din), 64'd0);
    check_eq("rst_cmdack", 64'(o_cmd_ack), 64'd0);
    check_eq("rst_ackout", 64'(o_ack_out), 64'd0);
    check_eq("rst_dout",   64'(o_dout),    64'd0);
    check_eq("rst_busy",   64'(o_busy),    64'd0);
    rst = 1'b1;
    step(2);
    check_eq("idle_busy", 64'(o_busy), 64'd0);

    // T1: write 0xA5 with START and STOP, slave ACK=0
    clear_log(); lat = 2; n0 = n_cack;
    i_din = 8'hA5; i_start = 1'b1; i_stop = 1'b1; i_write = 1'b1; i_ena = 1'b1;
    wait_ack("t1");
    check_eq("t1_ackout", 64'(o_ack_out), 64'd0);
    check_eq("t1_busy",   64'(o_busy),    64'd0);
    clear_cmd(); step(3);
    check_eq("t1_ncack", 64'(n_cack - n0), 64'd1);
    log_sig(sig, wb);
    check_eq("t1_seq",   sig, exp_sig(1'b1, 1'b0, 1'b1));
    check_eq("t1_wbits", 64'(wb), 64'h00A5);

    // T1b: write 0x3C with STOP only, slave NACK
    clear_log(); n0 = n_cack; dq.push_back(1'b1);
    i_din = 8'h3C; i_stop = 1'b1; i_write = 1'b1;
    wait_ack("t1b");
    check_eq("t1b_ackout", 64'(o_ack_out), 64'd1);
    clear_cmd(); step(3);
    log_sig(sig, wb);
    check_eq("t1b_seq",   sig, exp_sig(1'b0, 1'b0, 1'b1));
    check_eq("t1b_wbits", 64'(wb), 64'h003C);

    // T2: read with NACK and STOP, data 0,0,1,1,1,1,0,0
    clear_log(); n0 = n_cack;
    dq = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    i_read = 1'b1; i_ack_in = 1'b1; i_stop = 1'b1;
    wait_ack("t2");
    check_eq("t2_dout",   64'(o_dout),    64'h3C);
    check_eq("t2_ackout", 64'(o_ack_out), 64'd1);
    clear_cmd(); i_ack_in = 1'b0; step(3);
    check_eq("t2_ncack", 64'(n_cack - n0), 64'd1);
    log_sig(sig, wb);
    check_eq("t2_seq",   sig, exp_sig(1'b0, 1'b1, 1'b1));
    check_eq("t2_wbits", 64'(wb), 64'h0001);

    // Read beats write; bare read with ACK=0, data 0x81
    clear_log();
    dq = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    i_din = 8'hFF; i_read = 1'b1; i_write = 1'b1;
    wait_ack("prio");
    check_eq("prio_dout", 64'(o_dout), 64'h81);
    clear_cmd(); step(3);
    log_sig(sig, wb);
    check_eq("prio_seq",   sig, exp_sig(1'b0, 1'b1, 1'b0));
    check_eq("prio_wbits", 64'(wb), 64'h0000);

    // Bare START
    clear_log(); n0 = n_cack;
    i_start = 1'b1;
    wait_ack("bare");
    clear_cmd(); step(3);
    check_eq("bare_ncack", 64'(n_cack - n0), 64'd1);
    log_sig(sig, wb);
    check_eq("bare_seq", sig, 64'd1);

    // T3: engine acks the cycle after each command, write 0xFF, slave NACK
    clear_log(); lat = 1; n0 = n_cack; dq.push_back(1'b1);
    i_din = 8'hFF; i_write = 1'b1;
    k = 0; first = 0;
    while (k < 100) begin
      step(1);
      k++;
      if (first == 0 && o_bit_cmd != 3'd0) first = k;
      if (o_cmd_ack === 1'b1) break;
    end
    check_eq("t3_ack",    64'(o_cmd_ack),  64'd1);
    check_eq("t3_clks",   64'(k - first),  64'd18);
    check_eq("t3_ackout", 64'(o_ack_out),  64'd1);
    step(1);  // command bits still asserted through the holdoff cycle
    check_eq("t3_hold_busy", 64'(o_busy),    64'd0);
    check_eq("t3_hold_cmd",  64'(o_bit_cmd), 64'd0);
    clear_cmd(); step(3);
    check_eq("t3_ncack", 64'(n_cack - n0), 64'd1);
    log_sig(sig, wb);
    check_eq("t3_seq",   sig, exp_sig(1'b0, 1'b0, 1'b0));
    check_eq("t3_wbits", 64'(wb), 64'h00FF);

    // T4: arbitration lost during the 4th data bit of a write of 0x5A
    clear_log(); lat = 3; n0 = n_cack;
    i_din = 8'h5A; i_write = 1'b1;
    for (int j = 0; j < 200 && log_c.size() < 3; j++) step(1);
    step(1);
    check_eq("t4_pre_cmd", 64'(o_bit_cmd), 64'd3);
    check_eq("t4_pre_din", 64'(o_bit_din), 64'd1);
    i_bit_al = 1'b1;
    step(1);
    i_bit_al = 1'b0;
    check_eq("t4_cmd",    64'(o_bit_cmd), 64'd0);
    check_eq("t4_busy",   64'(o_busy),    64'd0);
    check_eq("t4_cmdack", 64'(o_cmd_ack), 64'd1);
    check_eq("t4_ackout", 64'(o_ack_out), 64'd1);
    check_eq("t4_dout",   64'(o_dout),    64'h81);
    clear_cmd(); step(3);
    check_eq("t4_ncack", 64'(n_cack - n0), 64'd1);
    check_eq("t4_nlog",  64'(log_c.size()), 64'd3);
    log_sig(sig, wb);
    check_eq("t4_wbits", 64'(wb), 64'h0002);

    // T5a: soft reset in the middle of a read
    clear_log(); lat = 2; n0 = n_cack;
    dq = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    i_read = 1'b1; i_stop = 1'b1;
    for (int j = 0; j < 200 && log_c.size() < 2; j++) step(1);
    check_eq("t5a_pre_busy", 64'(o_busy), 64'd1);
    i_core_rst = 1'b1; clear_cmd();
    step(1);
    i_core_rst = 1'b0;
    check_eq("t5a_cmd",    64'(o_bit_cmd), 64'd0);
    check_eq("t5a_din",    64'(o_bit_din), 64'd0);
    check_eq("t5a_busy",   64'(o_busy),    64'd0);
    check_eq("t5a_cmdack", 64'(o_cmd_ack), 64'd0);
    check_eq("t5a_ackout", 64'(o_ack_out), 64'd0);
    check_eq("t5a_dout",   64'(o_dout),    64'd0);
    step(5);
    check_eq("t5a_ncack", 64'(n_cack - n0), 64'd0);

    // T5b: asynchronous reset in the middle of a write of 0xE3
    clear_log(); n0 = n_cack;
    i_din = 8'hE3; i_start = 1'b1; i_write = 1'b1;
    for (int j = 0; j < 200 && log_c.size() < 3; j++) step(1);
    step(1);
    check_eq("t5b_pre_cmd", 64'(o_bit_cmd), 64'd3);
    check_eq("t5b_pre_din", 64'(o_bit_din), 64'd1);
    rst = 1'b0; clear_cmd();
    #1;
    check_eq("t5b_cmd",  64'(o_bit_cmd), 64'd0);
    check_eq("t5b_din",  64'(o_bit_din), 64'd0);
    check_eq("t5b_busy", 64'(o_busy),    64'd0);
    step(2);
    rst = 1'b1;
    step(5);
    check_eq("t5b_ncack", 64'(n_cack - n0), 64'd0);
    check_eq("t5b_idle",  64'(o_bit_cmd),   64'd0);

    // T6: i_ena low holds off the command; raising it issues WRITE one clock later
    clear_log(); lat = 0;
    i_ena = 1'b0; i_din = 8'h80; i_write = 1'b1;
    nn = 0;
    repeat (20) begin
      step(1);
      if (o_bit_cmd != 3'd0 || o_busy) nn++;
    end
    check_eq("t6_held", 64'(nn), 64'd0);
    i_ena = 1'b1;
    step(1);
    check_eq("t6_cmd", 64'(o_bit_cmd), 64'd3);
    check_eq("t6_din", 64'(o_bit_din), 64'd1);
    wait_ack("t6");
    clear_cmd(); step(3);
    log_sig(sig, wb);
    check_eq("t6_seq",   sig, exp_sig(1'b0, 1'b0, 1'b0));
    check_eq("t6_wbits", 64'(wb), 64'h0080);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
